fdiv_issue: RTL and testbench
=============================

Name: fdiv_issue

Overview:
- Requester-side controller for the iterative divide/square-root FSM.
- Accepts div/sqrt requests from the FPU pipeline over a valid/ready handshake and issues a one-cycle start with op_type to the divider.
- Waits for the divider's done pulse, then holds a tagged response until the pipeline accepts it.
- Handles pipeline flush; the divider cannot be aborted, so a flushed operation is drained, not cancelled.

Parameters:
- TAGW, 5, width of the request/response tag.
- CNTW, 5, width of the latency counter.
- TIMEOUT, 31, watchdog limit in WAIT cycles; must be < 2^CNTW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  1  0 = divide, 1 = square root.
- req_tag  in  TAGW  pipeline tag for the request.
- flush  in  1  kill any operation not yet returned.
- div_start  out  1  one-cycle start pulse to the divider.
- div_op_type  out  1  op type for the divider; valid during div_start.
- div_done  in  1  one-cycle completion pulse from the divider.
- div_error  in  1  divider error; sampled with div_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_tag  out  TAGW  tag of the completed operation.
- rsp_op  out  1  op of the completed operation.
- rsp_error  out  1  div_error captured at done, or watchdog expiry.
- rsp_cycles  out  CNTW  number of WAIT cycles before done.
- busy  out  1  state is not IDLE.
- hung  out  1  sticky watchdog flag; cleared only by reset.

Behaviour:
- Reset values: state=IDLE; all outputs 0 except req_ready=1; tag, op, count and error registers 0.
- State encoding: IDLE, LAUNCH, WAIT, RESP, DRAIN, HUNG. Outputs are registered or decoded from state only; no combinational path from req_valid to div_start.
- IDLE:
  - req_ready=1.
  - On req_valid&&!flush: capture req_tag/req_op, clear count, go to LAUNCH.
  - On req_valid&&flush: drop the request, stay in IDLE.
- LAUNCH:
  - div_start=1 and div_op_type=captured op, for exactly one cycle.
  - Next state WAIT, or DRAIN if flush.
- WAIT:
  - count increments each cycle, saturating at TIMEOUT.
  - div_done&&!flush: capture div_error, go to RESP.
  - div_done&&flush: go to IDLE; no response is produced.
  - flush without done: go to DRAIN.
  - count==TIMEOUT with no done: rsp_error=1, hung=1, go to RESP.
- Expected latency, start cycle to done: divide 9 cycles, sqrt 14 cycles. rsp_cycles reports the WAIT-cycle count exactly.
- RESP:
  - rsp_valid=1; rsp_tag, rsp_op, rsp_error and rsp_cycles are held stable until the handshake.
  - rsp_valid&&rsp_ready: go to IDLE, or to HUNG if hung=1.
  - flush in RESP: drop the response and go to IDLE, or to HUNG if hung=1.
  - flush has priority over rsp_ready in the same cycle.
- DRAIN:
  - rsp_valid=0, req_ready=0.
  - Wait for div_done, discard it, go to IDLE.
  - The watchdog also runs here; on expiry go to HUNG.
- HUNG:
  - req_ready=0 and div_start never asserts.
  - Exit only via reset. This prevents a late div_done from being attributed to a new operation.
- div_done seen in IDLE, LAUNCH or RESP is ignored. The bench treats it as a protocol violation (assertion).
- At most one operation is outstanding; no request is accepted while a response is pending (no bypass).
- Reset asserted mid-operation returns to IDLE at once. The divider shares the reset net and also returns to its idle state.

Decomposition:
- Shared FPU package:
  - state enumeration constants for this block;
  - op-type constants DIV=0 and SQRT=1, shared with the divider FSM;
  - nominal latency constants DIV_LAT=9 and SQRT_LAT=14 for assertions.
- One sub-module, fdiv_watchdog: saturating CNTW counter with clear/enable and an expiry compare against TIMEOUT. Reused by WAIT and DRAIN.

Test Plan:
- Divide request, tag 5'h0A, divider model done 9 cycles after start, rsp_ready=1 -> single div_start with div_op_type=0; rsp_valid for 1 cycle with rsp_tag=0A, rsp_op=0, rsp_cycles=9, rsp_error=0.
- Sqrt request, tag 5'h13, done after 14 cycles, rsp_ready held low for 6 cycles -> div_op_type=1; rsp fields stable for all 6 cycles; rsp_cycles=14; req_ready=0 until the handshake.
- Divide request, flush 3 cycles after start -> DRAIN; the done at cycle 9 is discarded; no rsp_valid; req_ready=1 the cycle after done; next request issues normally.
- flush coincident with div_done in WAIT, and separately with rsp_ready in RESP -> no response delivered in either case; back to IDLE.
- Divider model never returns done -> rsp_valid with rsp_error=1 and rsp_cycles=31; hung=1; HUNG entered; a new req_valid gets req_ready=0 and no div_start; reset pulse (low) clears hung and returns req_ready=1.
- Reset driven low mid-WAIT, asynchronously between clock edges -> busy, rsp_valid and div_start go to 0 immediately; after release a sqrt request completes correctly.

Source files
------------

// File: rtl/fdiv_pkg.sv
// ----------------------------------------------------------------------------
// fdiv_pkg: shared FPU divide/sqrt definitions (issue states, op codes, latency)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HUNG   = 3'd5
  } fdiv_state_e;

  // Op encoding is shared with the divider FSM.
  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  localparam int DIV_LAT  = 9;
  localparam int SQRT_LAT = 14;

endpackage

`default_nettype wire

// File: rtl/fdiv_watchdog.sv
// ----------------------------------------------------------------------------
// fdiv_watchdog: saturating latency counter with clear/enable and expiry flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fdiv_watchdog #(
  parameter int CNTW    = 5,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CNTW-1:0] count_o,
  output logic            expired_o
);

  localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT);

  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/fdiv_issue.sv
// ----------------------------------------------------------------------------
// fdiv_issue: issues div/sqrt requests to the iterative divider and returns
// tagged responses; flushed operations are drained, watchdog expiry is sticky.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fdiv_issue
  import fdiv_pkg::*;
#(
  parameter int TAGW    = 5,
  parameter int CNTW    = 5,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [TAGW-1:0] req_tag,
  input  logic            flush,
  output logic            div_start,
  output logic            div_op_type,
  input  logic            div_done,
  input  logic            div_error,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_op,
  output logic            rsp_error,
  output logic [CNTW-1:0] rsp_cycles,
  output logic            busy,
  output logic            hung
);

  fdiv_state_e     state_q, state_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic            op_q, op_d;
  logic            err_q, err_d;
  logic            hung_q, hung_d;

  logic            wd_clr;
  logic            wd_en;
  logic [CNTW-1:0] wd_count;
  logic            wd_expired;

  fdiv_watchdog #(
    .CNTW    (CNTW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .count_o   (wd_count),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    op_d    = op_q;
    err_d   = err_q;
    hung_d  = hung_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          tag_d   = req_tag;
          op_d    = req_op;
          err_d   = 1'b0;
          wd_clr  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        // The done cycle itself counts as a WAIT cycle.
        wd_en = 1'b1;
        if (div_done) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            err_d   = div_error;
            state_d = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          hung_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush) begin
          state_d = hung_q ? ST_HUNG : ST_IDLE;
        end else if (rsp_ready) begin
          state_d = hung_q ? ST_HUNG : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        wd_en = 1'b1;
        if (div_done) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          hung_d  = 1'b1;
          state_d = ST_HUNG;
        end
      end
      ST_HUNG: begin
        // A late done must never be attributed to a new operation.
        state_d = ST_HUNG;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      hung_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      err_q   <= err_d;
      hung_q  <= hung_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign div_start   = (state_q == ST_LAUNCH);
  assign div_op_type = div_start & op_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_tag     = tag_q;
  assign rsp_op      = op_q;
  assign rsp_error   = err_q;
  assign rsp_cycles  = wd_count;
  assign hung        = hung_q;

endmodule

`default_nettype wire

// File: tb/tb_fdiv_issue.sv
// ----------------------------------------------------------------------------
// tb_fdiv_issue: directed self-checking bench for fdiv_issue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fdiv_issue;
  import fdiv_pkg::*;

  localparam int TAGW    = 5;
  localparam int CNTW    = 5;
  localparam int TIMEOUT = 31;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_op;
  logic [TAGW-1:0] req_tag;
  logic            flush;
  logic            div_start;
  logic            div_op_type;
  logic            div_done;
  logic            div_error;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_op;
  logic            rsp_error;
  logic [CNTW-1:0] rsp_cycles;
  logic            busy;
  logic            hung;

  int checks     = 0;
  int failures   = 0;
  int start_cnt  = 0;
  int hs_cnt     = 0;
  int exp_starts = 0;
  int exp_hs     = 0;

  always #5 clk = ~clk;

  fdiv_issue #(
    .TAGW    (TAGW),
    .CNTW    (CNTW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_tag     (req_tag),
    .flush       (flush),
    .div_start   (div_start),
    .div_op_type (div_op_type),
    .div_done    (div_done),
    .div_error   (div_error),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_op      (rsp_op),
    .rsp_error   (rsp_error),
    .rsp_cycles  (rsp_cycles),
    .busy        (busy),
    .hung        (hung)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the LAUNCH cycle.
  task automatic issue(input logic op, input logic [TAGW-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    exp_starts++;
  endtask

  // Divider model: done pulse lat cycles after the start cycle.
  task automatic run_done(input int lat, input logic err);
    repeat (lat) tick();
    div_done  = 1'b1;
    div_error = err;
    tick();
    div_done  = 1'b0;
    div_error = 1'b0;
  endtask

  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (rsp_valid && rsp_ready && !flush) hs_cnt++;
    if (div_done && (req_ready || div_start || rsp_valid))
      check("done_outside_wait_drain", 1, 0);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_tag   = '0;
    flush     = 1'b0;
    div_done  = 1'b0;
    div_error = 1'b0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_hung", hung, 0);
    check("rst_rsp_cycles", rsp_cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Divide, immediate accept.
    rsp_ready = 1'b1;
    issue(OP_DIV, 5'h0A);
    check("t1_start", div_start, 1);
    check("t1_optype", div_op_type, 0);
    check("t1_req_ready", req_ready, 0);
    run_done(DIV_LAT, 1'b0);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_tag", rsp_tag, 5'h0A);
    check("t1_rsp_op", rsp_op, 0);
    check("t1_rsp_cycles", rsp_cycles, 9);
    check("t1_rsp_error", rsp_error, 0);
    exp_hs++;
    tick();
    check("t1_rsp_gone", rsp_valid, 0);
    check("t1_idle", req_ready, 1);
    check("t1_starts", start_cnt, exp_starts);
    check("t1_hs", hs_cnt, exp_hs);

    // Sqrt with backpressure.
    rsp_ready = 1'b0;
    issue(OP_SQRT, 5'h13);
    check("t2_optype", div_op_type, 1);
    run_done(SQRT_LAT, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("t2_hold_valid", rsp_valid, 1);
      check("t2_hold_tag", rsp_tag, 5'h13);
      check("t2_hold_op", rsp_op, 1);
      check("t2_hold_cycles", rsp_cycles, 14);
      check("t2_hold_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    exp_hs++;
    tick();
    check("t2_idle", req_ready, 1);
    check("t2_hs", hs_cnt, exp_hs);

    // Flush during WAIT: drain the divider.
    issue(OP_DIV, 5'h05);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_drain_busy", busy, 1);
    check("t3_drain_rsp", rsp_valid, 0);
    check("t3_drain_req_ready", req_ready, 0);
    repeat (5) tick();
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    check("t3_idle_after_done", req_ready, 1);
    check("t3_no_rsp", hs_cnt, exp_hs);
    issue(OP_DIV, 5'h07);
    check("t3_next_start", div_start, 1);
    run_done(DIV_LAT, 1'b1);
    check("t3_next_tag", rsp_tag, 5'h07);
    check("t3_next_err", rsp_error, 1);
    check("t3_next_cycles", rsp_cycles, 9);
    exp_hs++;
    tick();
    check("t3_next_idle", req_ready, 1);

    // Flush coincident with done in WAIT.
    issue(OP_SQRT, 5'h11);
    repeat (SQRT_LAT) tick();
    div_done = 1'b1;
    flush    = 1'b1;
    tick();
    div_done = 1'b0;
    flush    = 1'b0;
    check("t4a_idle", req_ready, 1);
    check("t4a_no_rsp", rsp_valid, 0);
    tick();
    check("t4a_hs", hs_cnt, exp_hs);

    // Flush coincident with rsp_ready in RESP.
    rsp_ready = 1'b0;
    issue(OP_DIV, 5'h12);
    run_done(DIV_LAT, 1'b0);
    check("t4b_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    rsp_ready = 1'b0;
    check("t4b_dropped", rsp_valid, 0);
    check("t4b_idle", req_ready, 1);
    check("t4b_hs", hs_cnt, exp_hs);

    // Divider never answers: watchdog.
    issue(OP_DIV, 5'h1F);
    n = 0;
    while (!rsp_valid && n < 64) begin
      tick();
      n++;
    end
    check("t5_timeout_latency", n, 33);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_error", rsp_error, 1);
    check("t5_rsp_cycles", rsp_cycles, 31);
    check("t5_hung", hung, 1);
    check("t5_rsp_tag", rsp_tag, 5'h1F);
    rsp_ready = 1'b1;
    exp_hs++;
    tick();
    rsp_ready = 1'b0;
    check("t5_hung_busy", busy, 1);
    check("t5_hung_req_ready", req_ready, 0);
    check("t5_hung_rsp", rsp_valid, 0);
    req_valid = 1'b1;
    req_tag   = 5'h03;
    repeat (4) tick();
    check("t5_hung_no_accept", req_ready, 0);
    check("t5_hung_no_start", start_cnt, exp_starts);
    req_valid = 1'b0;
    div_done  = 1'b1;
    tick();
    div_done  = 1'b0;
    check("t5_late_done_hung", busy, 1);
    check("t5_late_done_rsp", rsp_valid, 0);
    #2 reset = 1'b0;
    #1;
    check("t5_reset_hung", hung, 0);
    check("t5_reset_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Asynchronous reset mid-WAIT.
    rsp_ready = 1'b1;
    issue(OP_DIV, 5'h02);
    repeat (4) tick();
    check("t6_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_rsp", rsp_valid, 0);
    check("t6_async_start", div_start, 0);
    check("t6_async_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    issue(OP_SQRT, 5'h14);
    check("t6_optype", div_op_type, 1);
    run_done(SQRT_LAT, 1'b0);
    check("t6_rsp_valid", rsp_valid, 1);
    check("t6_rsp_tag", rsp_tag, 5'h14);
    check("t6_rsp_op", rsp_op, 1);
    check("t6_rsp_cycles", rsp_cycles, 14);
    check("t6_rsp_error", rsp_error, 0);
    exp_hs++;
    tick();
    check("t6_idle", req_ready, 1);
    check("t6_starts", start_cnt, exp_starts);
    check("t6_hs", hs_cnt, exp_hs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
